// File: rtl/half_adder.sv
// half_adder: registered per-bit half adder with valid flag and a saturating carry-event counter.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             valid,
    output logic [CNT_W-1:0] carry_cnt
);
    logic [WIDTH-1:0] s_q, s_d, c_q, c_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_evt;

    always_comb begin
        carry_evt = en && |(x & y);
        s_d       = en ? x ^ y : s_q;
        c_d       = en ? x & y : c_q;
        valid_d   = en;
        // clr beats an increment; the counter sticks at all-ones
        cnt_d     = clr ? '0 : (carry_evt && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s_q     <= s_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign valid     = valid_q;
    assign carry_cnt = cnt_q;
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: three half_adder instances (W=1, W=4, CNT_W=2) share one stimulus stream checked against a queue scoreboard.
module tb_half_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0, clr = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic [3:0] s4, c4;
    logic s1, c1, s2, c2, v4, v1, v2;
    logic [15:0] cnt4, cnt1;
    logic [1:0] cnt2;
    int total = 0, bad = 0;

    typedef struct {
        logic [3:0]  s, c;
        logic        v;
        logic [15:0] cnt4, cnt1;
        logic [1:0]  cnt2;
    } exp_t;
    exp_t sb[$];
    exp_t m;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(4), .CNT_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x4), .y(y4),
        .s(s4), .c(c4), .valid(v4), .carry_cnt(cnt4)
    );
    half_adder #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x4[0]), .y(y4[0]),
        .s(s1), .c(c1), .valid(v1), .carry_cnt(cnt1)
    );
    half_adder #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x4[0]), .y(y4[0]),
        .s(s2), .c(c2), .valid(v2), .carry_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".s4"}, s4, e.s);
        chk({tag, ".c4"}, c4, e.c);
        chk({tag, ".v4"}, v4, e.v);
        chk({tag, ".cnt4"}, cnt4, e.cnt4);
        chk({tag, ".s1"}, s1, e.s[0]);
        chk({tag, ".c1"}, c1, e.c[0]);
        chk({tag, ".v1"}, v1, e.v);
        chk({tag, ".cnt1"}, cnt1, e.cnt1);
        chk({tag, ".s2"}, s2, e.s[0]);
        chk({tag, ".c2"}, c2, e.c[0]);
        chk({tag, ".v2"}, v2, e.v);
        chk({tag, ".cnt2"}, cnt2, e.cnt2);
    endtask

    task automatic model_reset();
        m = '{s: '0, c: '0, v: 1'b0, cnt4: '0, cnt1: '0, cnt2: '0};
        sb.delete();
    endtask

    task automatic cycle(input string tag, input logic e, input logic cl, input logic [3:0] xv, input logic [3:0] yv);
        exp_t got;
        en = e; clr = cl; x4 = xv; y4 = yv;
        if (e) begin
            m.s = xv ^ yv;
            m.c = xv & yv;
        end
        m.v = e;
        m.cnt4 = cl ? 16'd0 : (e && (xv & yv) != 0 && m.cnt4 != 16'hffff) ? m.cnt4 + 16'd1 : m.cnt4;
        m.cnt1 = cl ? 16'd0 : (e && xv[0] && yv[0] && m.cnt1 != 16'hffff) ? m.cnt1 + 16'd1 : m.cnt1;
        m.cnt2 = cl ? 2'd0 : (e && xv[0] && yv[0] && m.cnt2 != 2'd3) ? m.cnt2 + 2'd1 : m.cnt2;
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) chk({tag, ".sb_empty"}, 0, 1);
        else begin
            got = sb.pop_front();
            check_all(tag, got);
        end
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all("reset", m);
        @(negedge clk) rst_n = 1'b1;
        cycle("tt00", 1, 0, 4'b0000, 4'b0000);
        cycle("tt01", 1, 0, 4'b0000, 4'b0001);
        cycle("tt10", 1, 0, 4'b0001, 4'b0000);
        cycle("tt11", 1, 0, 4'b0001, 4'b0001);
        cycle("w4", 1, 0, 4'b1100, 4'b1010);
        cycle("hold_a", 0, 0, 4'b1111, 4'b1111);
        cycle("hold_b", 0, 0, 4'b0101, 4'b0011);
        for (int i = 0; i < 5; i++) cycle("sat", 1, 0, 4'b0001, 4'b0001);
        cycle("clr_pri", 1, 1, 4'b0001, 4'b0001);
        cycle("clr_only", 0, 1, 4'b0000, 4'b0000);
        for (int i = 0; i < 40; i++)
            cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 4'($urandom), 4'($urandom));
        cycle("pre_rst", 1, 0, 4'b1111, 4'b0111);
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst", m);
        @(posedge clk);
        #1 check_all("rst_held", m);
        @(negedge clk) rst_n = 1'b1;
        cycle("post_rst_idle", 0, 0, 4'b1111, 4'b1111);
        cycle("post_rst_en", 1, 0, 4'b1011, 4'b1101);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the operand bit width (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the carry-event counter width (legal range 1..32).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: when high, x and y are sampled this cycle.
REQ-006 The block SHALL have port x, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port y, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port s, output, WIDTH bits: registered per-bit sum.
REQ-009 The block SHALL have port c, output, WIDTH bits: registered per-bit carry.
REQ-010 The block SHALL have port valid, output, 1 bit: s and c hold the result of the previous enabled sample.
REQ-011 The block SHALL have port carry_cnt, output, CNT_W bits: count of enabled samples with any carry bit set.
REQ-012 The block SHALL have port clr, input, 1 bit: synchronous clear of carry_cnt.

Function
REQ-013 On each rising clk with en=1, the block SHALL register s[i] = x[i] XOR y[i] for every bit i.
REQ-014 On each rising clk with en=1, the block SHALL register c[i] = x[i] AND y[i] for every bit i; bits SHALL be independent, with no ripple between bits.
REQ-015 Latency SHALL be exactly one clock: operands sampled at edge N appear on s/c after edge N.
REQ-016 With en=0, s and c SHALL hold their last values, and valid SHALL be 0 from the next edge.
REQ-017 With en=1, valid SHALL be 1 after the edge.
REQ-018 With en=1 and (x AND y) nonzero, carry_cnt SHALL increment by 1.
REQ-019 carry_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-020 With clr=1, carry_cnt SHALL become 0 at the edge; clr SHALL take priority over a simultaneous increment.
REQ-021 clr SHALL NOT affect s, c or valid.
REQ-022 X-free inputs SHALL yield X-free outputs; no combinational path SHALL exist from any input to any output.

Reset
REQ-023 While rst_n=0, the block SHALL force s=0, c=0, valid=0 and carry_cnt=0 immediately, without waiting for clk.
REQ-024 Deassertion of rst_n SHALL take effect from the first rising clk edge at which rst_n=1; that edge SHALL process en/x/y normally.
REQ-025 Reset asserted mid-operation SHALL discard any pending result; valid SHALL stay 0 until a subsequent enabled sample.

Verification
REQ-026 With WIDTH=1, the bench SHALL apply en=1 and drive (x,y) = 00, 01, 10, 11 on consecutive cycles and SHALL check (c,s) = (0,0), (0,1), (0,1), (1,0) with one-cycle latency, and valid=1 each time.
REQ-027 With WIDTH=4, the bench SHALL apply x=4'b1100, y=4'b1010 with en=1 and SHALL check s=4'b0110, c=4'b1000 and carry_cnt incremented by 1.
REQ-028 The bench SHALL apply en=0 with changing x/y and SHALL check that s/c hold their values, valid=0 and carry_cnt is unchanged.
REQ-029 The bench SHALL assert rst_n=0 between clock edges after nonzero results and SHALL check that s, c, valid and carry_cnt read 0 before the next edge.
REQ-030 With CNT_W=2, the bench SHALL apply 5 enabled samples with x=y=1 and SHALL check carry_cnt = 3 (saturated); it SHALL then apply clr=1 together with a carry sample and SHALL check carry_cnt=0.
